// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-to-parallel deserialiser.
// Latency: n/a (types, constants and elaboration-time functions only).
// Backpressure: n/a.
// Optional feature macro: SIPO_PARITY_EN (adds one parity bit per frame).
package sipo_pkg;

    // Bit order inside the assembled word.
    typedef enum logic {
        SIPO_LSB_FIRST = 1'b0,
        SIPO_MSB_FIRST = 1'b1
    } sipo_order_e;

    // Counter width. There is headroom for WIDTH+1 so the parity-bit slot
    // can still be counted.
    function automatic int sipo_cnt_w(input int width);
        return $clog2(width + 2);
    endfunction

    // Serial bits per frame: the data bits, plus the parity bit when enabled.
    function automatic int sipo_frame_len(input int width);
`ifdef SIPO_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/sipo_out_hold.sv
// One-word output holding register with valid/ready handshake and sticky error flags.
// Latency: a completed word is visible on parallel_out_o/out_valid_o the cycle after load_vld_i.
// Backpressure: a word completing while the held word is unaccepted is dropped; overrun_o is then set.
// Ports:
//   clock, reset          rising-edge clock, async active-high reset
//   load_vld_i/_dat_i     word completed by the shifter this cycle
//   par_evt_i             parity mismatch detected on the completing frame
//   clear_err_i           clears sticky flags (a new event on the same edge wins)
//   out_ready_i           consumer accepts the held word
//   parallel_out_o        held word
//   out_valid_o           held word is valid
//   overrun_o             sticky: word dropped
//   parity_err_o          sticky: parity mismatch
module sipo_out_hold #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_vld_i,
    input  logic [WIDTH-1:0] load_dat_i,
    input  logic             par_evt_i,
    input  logic             clear_err_i,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] parallel_out_o,
    output logic             out_valid_o,
    output logic             overrun_o,
    output logic             parity_err_o
);

    logic [WIDTH-1:0] dat_q, dat_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             perr_q, perr_d;
    logic             take, load, drop;

    always_comb begin
        take    = valid_q && out_ready_i;
        // The slot is free if it is empty, or if it is emptied on this same edge.
        load    = load_vld_i && (!valid_q || out_ready_i);
        drop    = load_vld_i && valid_q && !out_ready_i;

        dat_d   = dat_q;
        valid_d = valid_q;
        if (load) begin
            dat_d   = load_dat_i;
            valid_d = 1'b1;
        end else if (take) begin
            valid_d = 1'b0;
        end

        // Set has priority over clear.
        ovr_d  = drop      | (ovr_q  & ~clear_err_i);
        perr_d = par_evt_i | (perr_q & ~clear_err_i);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dat_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            dat_q   <= dat_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            perr_q  <= perr_d;
        end
    end

    assign parallel_out_o = dat_q;
    assign out_valid_o    = valid_q;
    assign overrun_o      = ovr_q;
    assign parity_err_o   = perr_q;

endmodule

// File: rtl/sipo_deser.sv
// Parametrised serial-to-parallel deserialiser with frame sync and a one-word output holding register.
// Latency: the word is valid the cycle after the edge that accepts the last bit of its frame.
// Backpressure: none on the serial side; a completed word is dropped (sticky overrun) if the held word is unaccepted.
// Optional macro SIPO_PARITY_EN: frame = WIDTH data bits + 1 parity bit; PARITY_ODD selects the parity sense.
// Ports:
//   clock, reset                    rising-edge clock, async active-high reset
//   serial_in, serial_valid         qualified serial bit stream
//   sync                            restart the frame (the held word and flags are untouched)
//   clear_err                       clear the sticky flags
//   parallel_out, out_valid,        output word with valid/ready handshake
//   out_ready
//   bit_count                       bits accepted in the current frame
//   overrun, parity_err             sticky error flags
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MSB_FIRST  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          serial_in,
    input  logic                          serial_valid,
    input  logic                          sync,
    input  logic                          clear_err,
    output logic [WIDTH-1:0]              parallel_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [sipo_cnt_w(WIDTH)-1:0]  bit_count,
    output logic                          overrun,
    output logic                          parity_err
);

    localparam int          CW    = sipo_cnt_w(WIDTH);
    localparam int          FRAME = sipo_frame_len(WIDTH);
    localparam sipo_order_e ORDER = (MSB_FIRST != 0) ? SIPO_MSB_FIRST : SIPO_LSB_FIRST;

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done;
    logic             par_evt;

    // MSB-first shifts left and inserts at bit 0, so the first bit ends in the MSB.
    // LSB-first shifts right and inserts at the MSB, so the first bit ends in bit 0.
    function automatic logic [WIDTH-1:0] ins_bit(input logic [WIDTH-1:0] base, input logic b);
        if (ORDER == SIPO_MSB_FIRST) begin
            return {base[WIDTH-2:0], b};
        end
        return {b, base[WIDTH-1:1]};
    endfunction

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        if (sync) begin
            // A bit that arrives with sync is the first bit of the new frame.
            // A frame is at least two bits, so this edge can never complete a word.
            shift_d = '0;
            cnt_d   = '0;
            if (serial_valid) begin
                shift_d = ins_bit('0, serial_in);
                cnt_d   = CW'(1);
            end
        end else if (serial_valid) begin
            // Only data slots go into the shifter. The parity slot (count == WIDTH)
            // is only checked.
            if (cnt_q < CW'(WIDTH)) begin
                shift_d = ins_bit(shift_q, serial_in);
            end
            if (cnt_q == CW'(FRAME - 1)) begin
                done  = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

`ifdef SIPO_PARITY_EN
    // On the parity-bit edge, shift_q already holds all WIDTH data bits.
    assign par_evt = done && ((^shift_q ^ serial_in) != 1'(PARITY_ODD));
`else
    assign par_evt = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bit_count = cnt_q;

    // shift_d is the finished word on the completing edge in both frame formats.
    sipo_out_hold #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clock          (clock),
        .reset          (reset),
        .load_vld_i     (done),
        .load_dat_i     (shift_d),
        .par_evt_i      (par_evt),
        .clear_err_i    (clear_err),
        .out_ready_i    (out_ready),
        .parallel_out_o (parallel_out),
        .out_valid_o    (out_valid),
        .overrun_o      (overrun),
        .parity_err_o   (parity_err)
    );

endmodule

// File: tb/tb_sipo_deser.sv
module tb_sipo_deser;

    logic       clock = 1'b0;
    logic       reset;
    logic       serial_in, serial_valid, sync, clear_err, out_ready;

    logic [7:0] m_out, l_out;
    logic       m_valid, l_valid, m_ovr, l_ovr, m_perr, l_perr;
    logic [3:0] m_cnt, l_cnt;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp_msb;
        logic [7:0] exp_lsb;
    } vec_t;

    typedef struct {
        logic [7:0] msb;
        logic [7:0] lsb;
    } exp_t;

    vec_t vecs[6];
    exp_t sb_q[$];

    always #5 clock = ~clock;

    sipo_deser #(.WIDTH(8), .MSB_FIRST(1), .PARITY_ODD(0)) u_msb (
        .clock(clock), .reset(reset), .serial_in(serial_in), .serial_valid(serial_valid),
        .sync(sync), .clear_err(clear_err), .parallel_out(m_out), .out_valid(m_valid),
        .out_ready(out_ready), .bit_count(m_cnt), .overrun(m_ovr), .parity_err(m_perr)
    );

    sipo_deser #(.WIDTH(8), .MSB_FIRST(0), .PARITY_ODD(0)) u_lsb (
        .clock(clock), .reset(reset), .serial_in(serial_in), .serial_valid(serial_valid),
        .sync(sync), .clear_err(clear_err), .parallel_out(l_out), .out_valid(l_valid),
        .out_ready(out_ready), .bit_count(l_cnt), .overrun(l_ovr), .parity_err(l_perr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_bit(input logic b);
        serial_in    = b;
        serial_valid = 1'b1;
        tick();
        serial_valid = 1'b0;
        serial_in    = 1'b0;
    endtask

    // Sends the bits in time order d[7]..d[0], with up to max_gap idle cycles
    // after each bit. In parity builds an even-parity bit follows.
    task automatic send_word(input logic [7:0] d, input int max_gap);
        for (int i = 7; i >= 0; i--) begin
            send_bit(d[i]);
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) tick();
        end
`ifdef SIPO_PARITY_EN
        send_bit(^d);
`endif
    endtask

    // The scoreboard compares each word as the consumer accepts it.
    always @(negedge clock) begin
        if (!reset && mon_en && m_valid && out_ready) begin
            exp_t e;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual=%0h required=none", m_out);
            end else begin
                e = sb_q.pop_front();
                chk("sb_msb_word", {24'd0, m_out}, {24'd0, e.msb});
                chk("sb_lsb_word", {24'd0, l_out}, {24'd0, e.lsb});
                chk("sb_lsb_valid", {31'd0, l_valid}, 32'd1);
            end
        end
    end

    initial begin
        vecs[0] = '{8'hA6, 8'hA6, 8'h65};
        vecs[1] = '{8'h01, 8'h01, 8'h80};
        vecs[2] = '{8'hF0, 8'hF0, 8'h0F};
        vecs[3] = '{8'hC8, 8'hC8, 8'h13};
        vecs[4] = '{8'h3C, 8'h3C, 8'h3C};
        vecs[5] = '{8'hFF, 8'hFF, 8'hFF};

        reset = 1'b1; serial_in = 1'b0; serial_valid = 1'b0;
        sync = 1'b0; clear_err = 1'b0; out_ready = 1'b0;
        #3;
        chk("rst_word",   {24'd0, m_out}, 32'd0);
        chk("rst_valid",  {31'd0, m_valid}, 32'd0);
        chk("rst_count",  {28'd0, m_cnt}, 32'd0);
        chk("rst_overrun",{31'd0, m_ovr}, 32'd0);
        chk("rst_parity", {31'd0, m_perr}, 32'd0);
        tick();
        reset = 1'b0;

        // Reset in the middle of a frame.
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        chk("mid_count", {28'd0, m_cnt}, 32'd5);
        reset = 1'b1;
        #1;
        chk("midrst_count", {28'd0, m_cnt}, 32'd0);
        chk("midrst_word",  {24'd0, m_out}, 32'd0);
        chk("midrst_valid", {31'd0, m_valid}, 32'd0);
        tick();
        reset = 1'b0;

        // First word after reset: A6 in MSB-first order, 65 in LSB-first order.
        send_word(8'hA6, 0);
        chk("a6_word",  {24'd0, m_out}, 32'hA6);
        chk("a6_valid", {31'd0, m_valid}, 32'd1);
        chk("a6_count", {28'd0, m_cnt}, 32'd0);
        chk("a6_lsb",   {24'd0, l_out}, 32'h65);

        // The second word arrives back to back with no consumer, so it is dropped.
        send_word(8'h3C, 0);
        chk("ovr_word",  {24'd0, m_out}, 32'hA6);
        chk("ovr_flag",  {31'd0, m_ovr}, 32'd1);
        chk("ovr_lflag", {31'd0, l_ovr}, 32'd1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("clr_flag",  {31'd0, m_ovr}, 32'd0);
        chk("clr_valid", {31'd0, m_valid}, 32'd1);
        out_ready = 1'b1;
        tick();
        chk("drain_valid", {31'd0, m_valid}, 32'd0);

        // Table pass: random gaps first, then back to back.
        mon_en = 1'b1;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 6; i++) begin
                sb_q.push_back('{vecs[i].exp_msb, vecs[i].exp_lsb});
                send_word(vecs[i].din, (p == 0) ? 2 : 0);
            end
        end
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) tick();
        tick();
        chk("sb_drained", sb_q.size(), 32'd0);
        chk("sb_no_overrun", {31'd0, m_ovr}, 32'd0);
        mon_en    = 1'b0;
        out_ready = 1'b0;

        // Frame restart: three stale bits, then sync together with the first new bit.
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        chk("pre_sync_count", {28'd0, m_cnt}, 32'd3);
        sync = 1'b1;
        send_bit(1'b0);
        sync = 1'b0;
        chk("sync_count", {28'd0, m_cnt}, 32'd1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
`ifdef SIPO_PARITY_EN
        send_bit(1'b0);
`endif
        chk("sync_word",  {24'd0, m_out}, 32'h55);
        chk("sync_lsb",   {24'd0, l_out}, 32'hAA);
        chk("sync_valid", {31'd0, m_valid}, 32'd1);

        // A sync with no bit clears the frame but keeps the held word.
        send_bit(1'b1); send_bit(1'b0);
        sync = 1'b1;
        tick();
        sync = 1'b0;
        chk("sync0_count", {28'd0, m_cnt}, 32'd0);
        chk("sync0_valid", {31'd0, m_valid}, 32'd1);
        chk("sync0_word",  {24'd0, m_out}, 32'h55);
        chk("no_parity_err", {31'd0, m_perr}, 32'd0);

`ifdef SIPO_PARITY_EN
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 7; i >= 0; i--) send_bit(vecs[0].din[i]);
        send_bit(1'b0);
        chk("par_ok_err",  {31'd0, m_perr}, 32'd0);
        chk("par_ok_word", {24'd0, m_out}, 32'hA6);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 7; i >= 0; i--) send_bit(vecs[0].din[i]);
        send_bit(1'b1);
        chk("par_bad_err",   {31'd0, m_perr}, 32'd1);
        chk("par_bad_word",  {24'd0, m_out}, 32'hA6);
        chk("par_bad_valid", {31'd0, m_valid}, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
